// File: rtl/id_hazard_unit.sv
// id_hazard_unit: load-use stall detection and registered operand-forwarding
// selects for the five-stage pipeline. The destinations of the instructions in
// EX, MEM and WB are shadowed in a three-entry in-flight scoreboard.
module id_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter bit LOAD_EXTRA = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] id_wreg,
    input  logic              id_wen,
    input  logic              id_load,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  stall_count
);

    // Forward-select encodings, matching the EX operand mux.
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;  // producer result sits in EX/MEM
    localparam logic [1:0] SEL_WB  = 2'b10;  // producer result sits in MEM/WB

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] wreg;
        logic              wen;
        logic              load;
    } entry_t;

    localparam entry_t BUBBLE = '{v: 1'b0, wreg: '0, wen: 1'b0, load: 1'b0};

    entry_t e_q;
    entry_t m_q;
    logic   w_v_q;  // only occupancy is ever observed for the WB entry

    entry_t     e_next;
    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;
    logic       haz1;
    logic       haz2;
    logic       bubble;

    // An entry produces register r. x0 never hazards and is never forwarded.
    function automatic logic match(input entry_t e, input logic [REG_AW-1:0] r);
        return e.v & e.wen & (e.wreg == r) & (r != '0);
    endfunction

    // Load-use hazard for one source operand.
    function automatic logic load_haz(input logic use_src, input logic [REG_AW-1:0] r,
                                      input entry_t e, input entry_t m);
        return use_src & ((e.load & match(e, r)) |
                          (LOAD_EXTRA & m.load & match(m, r)));
    endfunction

    // Operand select for the ID instruction once it reaches EX; nearer producer wins.
    // A matching load in E never forwards: that case is a stall instead.
    function automatic logic [1:0] sel(input logic use_src, input logic [REG_AW-1:0] r,
                                       input entry_t e, input entry_t m);
        if (use_src & match(e, r) & ~e.load)
            return SEL_MEM;
        else if (use_src & match(m, r))
            return SEL_WB;
        else
            return SEL_RF;
    endfunction

    // Hazard decision and next E entry / forward selects from current state and ID.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        e_next     = BUBBLE;
        fwd_a_next = SEL_RF;
        fwd_b_next = SEL_RF;

        haz1   = load_haz(id_use1, id_rs1, e_q, m_q);
        haz2   = load_haz(id_use2, id_rs2, e_q, m_q);
        stall  = id_valid & ~flush & (haz1 | haz2);
        bubble = flush | stall;

        if (!bubble) begin
            e_next     = '{v: id_valid, wreg: id_wreg, wen: id_wen & id_valid, load: id_load};
            fwd_a_next = sel(id_use1, id_rs1, e_q, m_q);
            fwd_b_next = sel(id_use2, id_rs2, e_q, m_q);
        end
    end

    // Scoreboard advances every cycle; forward selects are registered alongside E.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q   <= BUBBLE;
            m_q   <= BUBBLE;
            w_v_q <= 1'b0;
            fwd_a <= SEL_RF;
            fwd_b <= SEL_RF;
        end else begin
            // NOTE: non-blocking assignments make M and W take the pre-edge E and M values.
            e_q   <= e_next;
            m_q   <= e_q;
            w_v_q <= m_q.v;
            fwd_a <= fwd_a_next;
            fwd_b <= fwd_b_next;
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (stall && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + 1'b1;
    end

    assign ex_valid  = e_q.v;
    assign mem_valid = m_q.v;
    assign wb_valid  = w_v_q;

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed self-checking bench for id_hazard_unit. Three instances share the
// ID stimulus: base (LOAD_EXTRA=0), extra-cycle memory (LOAD_EXTRA=1) and a
// 2-bit stall counter. Each step checks only the instance it targets.
module tb_id_hazard_unit;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use1;
    logic       id_use2;
    logic [4:0] id_wreg;
    logic       id_wen;
    logic       id_load;
    logic       flush;

    logic        stall_b, ex_valid_b, mem_valid_b, wb_valid_b;
    logic [1:0]  fwd_a_b, fwd_b_b;
    logic [15:0] count_b;

    logic        stall_x, ex_valid_x, mem_valid_x, wb_valid_x;
    logic [1:0]  fwd_a_x, fwd_b_x;
    logic [15:0] count_x;

    logic        stall_s, ex_valid_s, mem_valid_s, wb_valid_s;
    logic [1:0]  fwd_a_s, fwd_b_s;
    logic [1:0]  count_s;

    int compared   = 0;
    int mismatched = 0;

    id_hazard_unit #(.REG_AW(5), .LOAD_EXTRA(1'b0), .CNT_W(16)) dut_base (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_wreg(id_wreg), .id_wen(id_wen),
        .id_load(id_load), .flush(flush), .stall(stall_b), .fwd_a(fwd_a_b), .fwd_b(fwd_b_b),
        .ex_valid(ex_valid_b), .mem_valid(mem_valid_b), .wb_valid(wb_valid_b),
        .stall_count(count_b)
    );

    id_hazard_unit #(.REG_AW(5), .LOAD_EXTRA(1'b1), .CNT_W(16)) dut_extra (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_wreg(id_wreg), .id_wen(id_wen),
        .id_load(id_load), .flush(flush), .stall(stall_x), .fwd_a(fwd_a_x), .fwd_b(fwd_b_x),
        .ex_valid(ex_valid_x), .mem_valid(mem_valid_x), .wb_valid(wb_valid_x),
        .stall_count(count_x)
    );

    id_hazard_unit #(.REG_AW(5), .LOAD_EXTRA(1'b0), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_wreg(id_wreg), .id_wen(id_wen),
        .id_load(id_load), .flush(flush), .stall(stall_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s),
        .ex_valid(ex_valid_s), .mem_valid(mem_valid_s), .wb_valid(wb_valid_s),
        .stall_count(count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to one time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic valid, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] wreg,
                          input logic wen, input logic load);
        id_valid = valid;
        id_rs1   = rs1;
        id_use1  = u1;
        id_rs2   = rs2;
        id_use2  = u2;
        id_wreg  = wreg;
        id_wen   = wen;
        id_load  = load;
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #11;
        check("reset_stall", 16'(stall_b), 16'd0);
        check("reset_fwd_a", 16'(fwd_a_b), 16'd0);
        check("reset_ex_valid", 16'(ex_valid_b), 16'd0);
        reset = 1'b0;

        // ADD x5,x1,x2 then SUB x6,x5,x5 back to back.
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        check("add_stall", 16'(stall_b), 16'd0);
        tick();
        check("add_fwd_a", 16'(fwd_a_b), 16'd0);
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        check("sub_stall", 16'(stall_b), 16'd0);
        tick();
        check("sub_fwd_a", 16'(fwd_a_b), 16'd1);
        check("sub_fwd_b", 16'(fwd_b_b), 16'd1);
        check("sub_mem_valid", 16'(mem_valid_b), 16'd1);

        // XOR x10,x5,x1 with SUB between it and the ADD producer.
        set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd10, 1'b1, 1'b0);
        tick();
        check("xor_fwd_a", 16'(fwd_a_b), 16'd2);
        check("xor_fwd_b", 16'(fwd_b_b), 16'd0);
        check("xor_wb_valid", 16'(wb_valid_b), 16'd1);

        // LD x7 then AND x8,x7,x1 with single-cycle memory.
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        check("ld_stall", 16'(stall_b), 16'd0);
        tick();
        set_id(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);
        check("lu_stall_1", 16'(stall_b), 16'd1);
        tick();
        check("lu_bubble", 16'(ex_valid_b), 16'd0);
        check("lu_stall_2", 16'(stall_b), 16'd0);
        tick();
        check("lu_ex_valid", 16'(ex_valid_b), 16'd1);
        check("lu_fwd_a", 16'(fwd_a_b), 16'd2);
        check("lu_fwd_b", 16'(fwd_b_b), 16'd0);
        check("lu_count", count_b, 16'd1);

        // Same sequence with the extra memory cycle: two stall cycles.
        pulse_reset();
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);
        check("lx_stall_1", 16'(stall_x), 16'd1);
        tick();
        check("lx_stall_2", 16'(stall_x), 16'd1);
        check("lx_bubble", 16'(ex_valid_x), 16'd0);
        tick();
        check("lx_stall_3", 16'(stall_x), 16'd0);
        check("lx_count", count_x, 16'd2);
        tick();
        check("lx_ex_valid", 16'(ex_valid_x), 16'd1);
        check("lx_fwd_a", 16'(fwd_a_x), 16'd0);

        // Asynchronous reset in the middle of a stall.
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        check("mid_stall_pre", 16'(stall_x), 16'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_stall_drop", 16'(stall_x), 16'd0);
        check("mid_count_clr", count_x, 16'd0);
        check("mid_mem_valid", 16'(mem_valid_x), 16'd0);
        check("mid_base_count", count_b, 16'd0);
        reset = 1'b0;
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        check("post_rst_stall", 16'(stall_b), 16'd0);
        tick();
        check("post_rst_fwd_a", 16'(fwd_a_b), 16'd0);
        check("post_rst_fwd_b", 16'(fwd_b_b), 16'd0);
        check("post_rst_ex_valid", 16'(ex_valid_b), 16'd1);

        // x0 producer and consumer: never forwarded.
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0);
        check("x0_stall", 16'(stall_b), 16'd0);
        tick();
        check("x0_fwd_a", 16'(fwd_a_b), 16'd0);
        check("x0_fwd_b", 16'(fwd_b_b), 16'd0);

        // Load to x0 followed by an x0 reader: no stall.
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 5'd12, 1'b1, 1'b0);
        check("ld_x0_stall", 16'(stall_b), 16'd0);
        tick();

        // Load to x3, consumer names rs2=3 but does not read it.
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd3, 1'b0, 5'd13, 1'b1, 1'b0);
        check("unused_rs2_stall", 16'(stall_b), 16'd0);
        tick();
        check("unused_rs2_fwd_b", 16'(fwd_b_b), 16'd0);
        check("unused_rs2_ex_valid", 16'(ex_valid_b), 16'd1);

        // Flush overrides a load-use stall and inserts a bubble.
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 5'd14, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_stall", 16'(stall_b), 16'd0);
        tick();
        flush = 1'b0;
        check("flush_bubble", 16'(ex_valid_b), 16'd0);
        check("flush_fwd_a", 16'(fwd_a_b), 16'd0);

        // Five single-cycle load-use stalls: 2-bit counter saturates at 3.
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);
            tick();
            tick();
            if (i == 2)
                check("sat_count_3", 16'(count_s), 16'd3);
        end
        check("sat_count_hold", 16'(count_s), 16'd3);
        check("sat_base_count", count_b, 16'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
